// File: rtl/pid_seq.sv
// pid_seq: runs one ADC -> PID -> PWM update sequence per decimated trigger,
// with per-wait-state timeout, sticky overrun/fault flags and a cycle counter.
module pid_seq #(
  parameter int DW    = 12,
  parameter int DECIM = 1,
  parameter int TMO   = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  input  logic          enable,
  input  logic          adc_done,
  input  logic [DW-1:0] adc_data,
  input  logic          pid_done,
  input  logic          pwm_ready,
  input  logic          flag_clr,
  output logic          adc_start,
  output logic          pid_start,
  output logic [DW-1:0] pid_meas,
  output logic          pwm_load,
  output logic          busy,
  output logic          overrun,
  output logic          fault,
  output logic [15:0]   cycle_cnt
);

  typedef enum logic [2:0] {
    IDLE, ADC_REQ, ADC_WAIT, PID_REQ, PID_WAIT, PWM_WAIT, PWM_LOAD
  } state_t;

  state_t        state_q, state_d;
  logic          trigMeta_q, trigSync_q, trigPrev_q;
  logic          qualEdge, launchEdge;
  logic [7:0]    decimCnt_q, decimCnt_d;
  logic [15:0]   tmoCnt_q, tmoCnt_d;
  logic          inWait, waitExit, tmoExpired;
  logic [DW-1:0] meas_q, meas_d;
  logic [15:0]   cycleCnt_q, cycleCnt_d;
  logic          overrun_q, overrun_d, overrunSet;
  logic          fault_q, fault_d, faultSet;

  // trig is asynchronous: two flops to resolve metastability, a third for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trigMeta_q <= 1'b0;
      trigSync_q <= 1'b0;
      trigPrev_q <= 1'b0;
    end else begin
      trigMeta_q <= trig;
      trigSync_q <= trigMeta_q;
      trigPrev_q <= trigSync_q;
    end
  end

  assign qualEdge = trigSync_q & ~trigPrev_q;

  // Decimation runs independently of the FSM so the launch phase never drifts
  always_comb begin
    decimCnt_d = decimCnt_q;
    launchEdge = 1'b0;
    if (qualEdge) begin
      if (decimCnt_q == 8'(DECIM - 1)) begin
        decimCnt_d = '0;
        launchEdge = 1'b1;
      end else begin
        decimCnt_d = decimCnt_q + 8'd1;
      end
    end
  end

  assign tmoExpired = (tmoCnt_q == 16'(TMO - 1));

  always_comb begin
    state_d  = state_q;
    meas_d   = meas_q;
    inWait   = 1'b0;
    waitExit = 1'b0;
    faultSet = 1'b0;
    case (state_q)
      IDLE:     if (launchEdge && enable) state_d = ADC_REQ;
      ADC_REQ:  state_d = ADC_WAIT;
      ADC_WAIT: begin
        inWait   = 1'b1;
        waitExit = adc_done;
        if (adc_done) begin
          meas_d  = adc_data;
          state_d = PID_REQ;
        end
      end
      PID_REQ:  state_d = PID_WAIT;
      PID_WAIT: begin
        inWait   = 1'b1;
        waitExit = pid_done;
        if (pid_done) state_d = PWM_WAIT;
      end
      PWM_WAIT: begin
        inWait   = 1'b1;
        waitExit = pwm_ready;
        if (pwm_ready) state_d = PWM_LOAD;
      end
      PWM_LOAD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Exit condition outranks expiry, so a response on the last allowed cycle still counts
    if (inWait && !waitExit && tmoExpired) begin
      faultSet = 1'b1;
      state_d  = IDLE;
    end
  end

  assign tmoCnt_d   = (inWait && !waitExit) ? tmoCnt_q + 16'd1 : '0;
  assign overrunSet = launchEdge && (state_q != IDLE);
  assign overrun_d  = overrunSet | (overrun_q & ~flag_clr);
  assign fault_d    = faultSet | (fault_q & ~flag_clr);
  assign cycleCnt_d = (state_q == PWM_LOAD) ? cycleCnt_q + 16'd1 : cycleCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      decimCnt_q <= '0;
      tmoCnt_q   <= '0;
      meas_q     <= '0;
      cycleCnt_q <= '0;
      overrun_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      decimCnt_q <= decimCnt_d;
      tmoCnt_q   <= tmoCnt_d;
      meas_q     <= meas_d;
      cycleCnt_q <= cycleCnt_d;
      overrun_q  <= overrun_d;
      fault_q    <= fault_d;
    end
  end

  assign adc_start = (state_q == ADC_REQ);
  assign pid_start = (state_q == PID_REQ);
  assign pwm_load  = (state_q == PWM_LOAD);
  assign busy      = (state_q != IDLE);
  assign pid_meas  = meas_q;
  assign overrun   = overrun_q;
  assign fault     = fault_q;
  assign cycle_cnt = cycleCnt_q;

endmodule
